// File: rtl/regfile_fwd_sb.sv
// Multi-port register file with write-to-read bypass, hardwired x0 and a pending-write scoreboard.
// Define RF_SCOREBOARD_EN to build the scoreboard; otherwise rd_busy and iss_stall are tied to 0.
module regfile_fwd_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NWR  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_stall
);

    localparam int NREG = 1 << AW;

    logic [XLEN-1:0] regs [NREG];

    // NOTE: the storage array is reset on purpose: every register must read 0 the moment rst_n drops.
    // Later ports overwrite earlier ones within the loop, so the highest write index wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && wr_addr[i*AW +: AW] != '0)
                    regs[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
            end
        end
    end

`ifdef RF_SCOREBOARD_EN
    logic [NREG-1:0] busy;
    logic [NREG-1:0] clr;
    logic [NREG-1:0] set;

    // A write this cycle retires the pending producer of its target register.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i] && wr_addr[i*AW +: AW] != '0)
                clr[wr_addr[i*AW +: AW]] = 1'b1;
        end
    end

    assign iss_stall = iss_en && (iss_addr != '0) && busy[iss_addr] && !clr[iss_addr];

    always_comb begin
        set = '0;
        if (iss_en && !iss_stall && iss_addr != '0)
            set[iss_addr] = 1'b1;
    end

    // Set is ORed after the clear mask, so a new issue wins over a same-cycle retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= set | (busy & ~clr);
    end
`else
    logic unused_iss;
    assign unused_iss = ^{iss_en, iss_addr};
    assign iss_stall  = 1'b0;
`endif

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] fwd;

        assign ra = rd_addr[j*AW +: AW];

        // NOTE: fwd gets its default before the loop, so no path leaves it unassigned (no latch).
        always_comb begin
            fwd = regs[ra];
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && wr_addr[i*AW +: AW] == ra)
                    fwd = wr_data[i*XLEN +: XLEN];
            end
        end

        // Forwarding is gated during reset so rd_data is 0 even with live write ports.
        assign rd_data[j*XLEN +: XLEN] = (!rst_n || ra == '0) ? '0 : fwd;

`ifdef RF_SCOREBOARD_EN
        assign rd_busy[j] = busy[ra] & ~clr[ra];
`else
        assign rd_busy[j] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Self-checking bench for regfile_fwd_sb: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model (array storage + busy table).
`timescale 1ns/1ps
module tb_regfile_fwd_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int NREG = 1 << AW;
`ifdef RF_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    bit                  clk;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                iss_stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] mregs [NREG];
    bit              mbusy [NREG];
    bit              m_stall;

    regfile_fwd_sb #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_stall (iss_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Does any enabled write port target register a (a != 0) this cycle?
    function automatic bit wrote(input logic [AW-1:0] a);
        for (int i = 0; i < NWR; i++)
            if (wr_en[i] && wr_addr[i*AW +: AW] == a && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
        if (rst_n !== 1'b1 || a == 0) return '0;
        for (int i = NWR - 1; i >= 0; i--)
            if (wr_en[i] && wr_addr[i*AW +: AW] == a) return wr_data[i*XLEN +: XLEN];
        return mregs[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        return SB && rst_n === 1'b1 && a != 0 && mbusy[a] && !wrote(a);
    endfunction

    function automatic bit exp_stall();
        return SB && rst_n === 1'b1 && iss_en && iss_addr != 0 && mbusy[iss_addr] && !wrote(iss_addr);
    endfunction

    // Reference model state update.
    always @(posedge clk or negedge rst_n) begin
        if (rst_n !== 1'b1) begin
            for (int r = 0; r < NREG; r++) begin
                mregs[r] = '0;
                mbusy[r] = 1'b0;
            end
        end else begin
            m_stall = exp_stall();
            if (SB) begin
                for (int r = 1; r < NREG; r++)
                    if (wrote(AW'(r))) mbusy[r] = 1'b0;
                if (iss_en && !m_stall && iss_addr != 0) mbusy[iss_addr] = 1'b1;
            end
            for (int i = 0; i < NWR; i++)
                if (wr_en[i] && wr_addr[i*AW +: AW] != 0)
                    mregs[wr_addr[i*AW +: AW]] = wr_data[i*XLEN +: XLEN];
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int j = 0; j < NRD; j++) begin
            check($sformatf("rd_data%0d", j), rd_data[j*XLEN +: XLEN], exp_read(rd_addr[j*AW +: AW]));
            check($sformatf("rd_busy%0d", j), rd_busy[j], exp_busy(rd_addr[j*AW +: AW]));
        end
        check("iss_stall", iss_stall, exp_stall());
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_addr  = {5'd7, 5'd5};
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        #2;
        check("reset rd_data", rd_data, 64'h0);
        check("reset rd_busy", rd_busy, 2'b00);
        check("reset stall", iss_stall, 1'b0);
        #10 rst_n = 1'b1;

        // Write x5, read it back, then reset mid-cycle.
        next_cycle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h1234};
        rd_addr = {5'd0, 5'd5};
        #2 check("x5 bypass", rd_data[31:0], 32'h1234);
        next_cycle();
        rd_addr = {5'd0, 5'd5};
        #1 check("x5 stored", rd_data[31:0], 32'h1234);
        #1 rst_n = 1'b0;
        #0.5 check("x5 async reset", rd_data[31:0], 32'h0);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h9999};
        iss_en = 1'b1; iss_addr = 5'd5;
        #0.1 check("fwd gated in reset", rd_data[31:0], 32'h0);
        next_cycle();
        #1 rst_n = 1'b1;
        for (int a = 0; a < NREG; a++) begin
            rd_addr[AW-1:0] = AW'(a);
            #0.05;
            check($sformatf("post-reset busy x%0d", a), rd_busy[0], 1'b0);
            check($sformatf("post-reset data x%0d", a), rd_data[31:0], 32'h0);
        end

        // Forward priority: port 1 beats port 0.
        next_cycle();
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h5555, 32'hAAAA};
        rd_addr = {5'd0, 5'd7};
        #2 check("x7 fwd priority", rd_data[31:0], 32'h5555);
        next_cycle();
        rd_addr = {5'd0, 5'd7};
        #2 check("x7 stored priority", rd_data[31:0], 32'h5555);

        // x0 is never written, never busy and never stalls.
        next_cycle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFF_FFFF};
        iss_en = 1'b1; iss_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        #2;
        check("x0 data", rd_data, 64'h0);
        check("x0 stall", iss_stall, 1'b0);
        check("x0 busy", rd_busy, 2'b00);
        next_cycle();
        rd_addr = {5'd0, 5'd0};
        #2 check("x0 stored", rd_data, 64'h0);

        // RAW on x3.
        next_cycle();
        iss_en = 1'b1; iss_addr = 5'd3; rd_addr = {5'd0, 5'd3};
        #2;
        check("raw issue stall", iss_stall, 1'b0);
        check("raw busy same cycle", rd_busy[0], 1'b0);
        repeat (2) begin
            next_cycle();
            rd_addr = {5'd0, 5'd3};
            #2 check("raw busy pending", rd_busy[0], SB);
        end
        next_cycle();
        wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h42, 32'h0};
        rd_addr = {5'd0, 5'd3};
        #2;
        check("raw busy write cycle", rd_busy[0], 1'b0);
        check("raw data write cycle", rd_data[31:0], 32'h42);
        next_cycle();
        rd_addr = {5'd0, 5'd3};
        #2 check("raw busy after", rd_busy[0], 1'b0);

        // WAW on x9, then issue in the retiring write cycle (set wins).
        next_cycle();
        iss_en = 1'b1; iss_addr = 5'd9;
        #2 check("waw first issue", iss_stall, 1'b0);
        next_cycle();
        iss_en = 1'b1; iss_addr = 5'd9;
        #2 check("waw second issue", iss_stall, SB);
        next_cycle();
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h1};
        #2 check("waw issue on write", iss_stall, 1'b0);
        next_cycle();
        rd_addr = {5'd0, 5'd9};
        #2 check("waw set wins", rd_busy[0], SB);

        // Randomized traffic on a small address window to force collisions.
        repeat (3000) begin
            next_cycle();
            wr_en = NWR'($urandom);
            for (int i = 0; i < NWR; i++) begin
                wr_addr[i*AW +: AW]   = AW'($urandom_range(0, 7));
                wr_data[i*XLEN +: XLEN] = $urandom;
            end
            for (int j = 0; j < NRD; j++)
                rd_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
            iss_en   = ($urandom_range(0, 2) != 0);
            iss_addr = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b1;
            end
        end

        next_cycle();
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
